fifo_tx_sched: RTL
==================

Name: fifo_tx_sched

Overview:
Read-side scheduler for the UART transmit FIFO. It drains bytes from the FIFO read port and sequences them one at a time into the UART transmitter using a start/busy handshake. It also enforces a programmable inter-byte gap and counts transmitted bytes. It sits entirely in the FIFO read clock domain, between the FIFO read port and the UART TX serializer.

Parameters:
DSIZE, 8, data width; must match the FIFO data width.
GAPW, 16, width of the inter-byte gap counter and of the gap_cycles input.
CNTW, 16, width of the sent-byte counter.

Ports:
rclk  input  1  FIFO read-domain clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  drain enable; level-sensitive.
gap_cycles  input  GAPW  idle cycles inserted after each byte completes (0 = none); sampled on entry to GAP.
fifo_empty  input  1  FIFO empty flag.
fifo_rdata  input  DSIZE  FIFO read data; combinationally valid at the read pointer while fifo_empty=0.
fifo_rinc  output  1  FIFO pop strobe; exactly one rclk cycle per byte.
tx_busy  input  1  transmitter busy; rises to acknowledge start, falls when the stop bit is done.
tx_start  output  1  transmit request; held high until tx_busy is seen high.
tx_data  output  DSIZE  byte presented to the transmitter; stable from tx_start rise until return to IDLE.
active  output  1  high in any state other than IDLE.
sent_cnt  output  CNTW  bytes completed since reset; wraps modulo 2^CNTW.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; fifo_rinc=0, tx_start=0, tx_data=0, active=0, sent_cnt=0, gap counter=0. Reset mid-byte abandons the byte. A byte that was already popped is lost; no re-pop.
- All outputs are registered.
- State IDLE:
  - Launch condition: en=1, fifo_empty=0 and tx_busy=0 at edge N.
  - On launch, at edge N: tx_data<=fifo_rdata, fifo_rinc<=1, tx_start<=1, state->START.
  - fifo_rinc and tx_start are therefore visible in cycle N+1.
- State START:
  - fifo_rinc<=0 at the next edge, giving exactly one pop per byte.
  - tx_start stays 1 until tx_busy=1 is sampled; then tx_start<=0 and state->WAIT_DONE.
  - No timeout; tx_start is held indefinitely.
- State WAIT_DONE: when tx_busy=0 is sampled:
  - sent_cnt<=sent_cnt+1, wrapping from all-ones to 0.
  - If gap_cycles=0, state->IDLE; otherwise load the gap counter with gap_cycles and state->GAP.
- State GAP: decrement the counter each cycle; at counter=1, state->IDLE. IDLE is reached exactly gap_cycles cycles after leaving WAIT_DONE.
- Back-to-back bytes (gap_cycles=0, FIFO non-empty, tx_busy falls at edge M):
  - WAIT_DONE->IDLE at edge M.
  - Next launch at edge M+1.
  - New tx_start visible in cycle M+2.
- en deassertion:
  - Takes effect only in IDLE; the in-flight byte always completes, including its gap.
  - en=0 in IDLE: no pop, outputs hold.
- FIFO empty: no launch; the scheduler never asserts fifo_rinc while fifo_empty=1. The empty flag is sampled only in IDLE.
- tx_busy already high in IDLE (transmitter owned elsewhere): no launch until it falls.
- tx_data holds its last value in IDLE; it is not cleared.
- Illegal or unused state encodings recover to IDLE on the next edge, with fifo_rinc=0 and tx_start=0.

Optional Feature:
FIFO_TX_PAUSE_EN
- Defined: adds input port pause (1 bit, after en), for software or XOFF flow control.
  - pause=1 blocks launch in IDLE only; bytes in START, WAIT_DONE or GAP complete normally.
  - While pause=1 in IDLE: fifo_rinc=0, tx_start=0, and FIFO contents are untouched.
- Undefined: the port is absent and behaviour is identical to pause=0.

Test Plan:
- Reset/idle: hold rst_n=0 with fifo_empty=0 and en=1, then release -> all outputs 0; first fifo_rinc pulse one cycle after the first edge with rst_n=1.
- Single byte: FIFO holds 8'hA5, gap_cycles=0, model asserts tx_busy 3 cycles after tx_start and holds it 20 cycles -> tx_data=8'hA5, one fifo_rinc pulse, tx_start high 3 cycles, sent_cnt=1, active falls in the cycle after busy falls.
- Burst with gap: FIFO holds 8'h01..8'h04, gap_cycles=5 -> four bytes in order, four single-cycle pops, exactly 5 idle cycles between each busy fall and the next IDLE, sent_cnt=4, then idle with fifo_empty=1.
- en drop mid-byte: deassert en during WAIT_DONE of byte 1 of 3 -> byte 1 completes, sent_cnt=1, no further fifo_rinc until en=1 again, then bytes 2 and 3 follow.
- Reset mid-byte: pulse rst_n low during WAIT_DONE -> outputs 0 immediately (async), sent_cnt=0, next launch takes the next FIFO entry.
- Counter wrap (CNTW=4) and pause (FIFO_TX_PAUSE_EN defined): send 17 bytes -> sent_cnt=1; pause=1 while FIFO non-empty -> no pops; pause=0 -> drain resumes next cycle.

Source files
------------

// File: rtl/fifo_tx_sched_if.sv
// fifo_tx_sched_if: FIFO read port plus UART TX start/busy handshake bundle.
interface fifo_tx_sched_if #(parameter int DSIZE = 8);
  logic             fifo_empty;
  logic [DSIZE-1:0] fifo_rdata;
  logic             fifo_rinc;
  logic             tx_busy;
  logic             tx_start;
  logic [DSIZE-1:0] tx_data;
  modport master (input fifo_empty, fifo_rdata, tx_busy, output fifo_rinc, tx_start, tx_data);
  modport slave (output fifo_empty, fifo_rdata, tx_busy, input fifo_rinc, tx_start, tx_data);
endinterface

// File: rtl/fifo_tx_sched.sv
// fifo_tx_sched: drains the TX FIFO one byte at a time into the UART transmitter with inter-byte gap and sent counter.
// Defining FIFO_TX_PAUSE_EN adds a pause input that blocks new launches.
module fifo_tx_sched #(
  parameter int DSIZE = 8,
  parameter int GAPW  = 16,
  parameter int CNTW  = 16
) (
  input  logic            rclk,
  input  logic            rst_n,
  input  logic            en,
`ifdef FIFO_TX_PAUSE_EN
  input  logic            pause,
`endif
  input  logic [GAPW-1:0] gap_cycles,
  fifo_tx_sched_if.master bus,
  output logic            active,
  output logic [CNTW-1:0] sent_cnt
);
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;
  state_t            state_q, state_d;
  logic              fifo_rinc_q, fifo_rinc_d;
  logic              tx_start_q, tx_start_d;
  logic              active_q, active_d;
  logic [DSIZE-1:0]  tx_data_q, tx_data_d;
  logic [CNTW-1:0]   sent_cnt_q, sent_cnt_d;
  logic [GAPW-1:0]   gap_q, gap_d;
  logic              blocked;
`ifdef FIFO_TX_PAUSE_EN
  assign blocked = pause;
`else
  assign blocked = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    fifo_rinc_d = 1'b0;
    tx_start_d  = tx_start_q;
    tx_data_d   = tx_data_q;
    sent_cnt_d  = sent_cnt_q;
    gap_d       = gap_q;
    case (state_q)
      IDLE: begin
        if (en && !blocked && !bus.fifo_empty && !bus.tx_busy) begin
          tx_data_d   = bus.fifo_rdata;
          fifo_rinc_d = 1'b1;
          tx_start_d  = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        if (bus.tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          sent_cnt_d = sent_cnt_q + CNTW'(1);
          gap_d      = gap_cycles;
          state_d    = (gap_cycles == '0) ? IDLE : GAP;
        end
      end
      GAP: begin
        gap_d   = gap_q - GAPW'(1);
        state_d = (gap_q <= GAPW'(1)) ? IDLE : GAP;
      end
      default: begin
        state_d    = IDLE;
        tx_start_d = 1'b0;
      end
    endcase
    active_d = (state_d != IDLE);
  end
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fifo_rinc_q <= 1'b0;
      tx_start_q  <= 1'b0;
      active_q    <= 1'b0;
      tx_data_q   <= '0;
      sent_cnt_q  <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      fifo_rinc_q <= fifo_rinc_d;
      tx_start_q  <= tx_start_d;
      active_q    <= active_d;
      tx_data_q   <= tx_data_d;
      sent_cnt_q  <= sent_cnt_d;
      gap_q       <= gap_d;
    end
  end
  assign bus.fifo_rinc = fifo_rinc_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign active        = active_q;
  assign sent_cnt      = sent_cnt_q;
endmodule
